register_file_sb: RTL
=====================

// Module: register_file_sb
// PURPOSE
//  Parametrised successor register file for the RISC datapath: NREG x NBIT, two combinational
//  read ports, two write ports (ALU writeback + load return), a per-register busy scoreboard for
//  outstanding loads, write-through bypass, optional hard-zero r0, and a multi-cycle clear sweep.
//  Sits between decode (AA/BA/DA) and the ALU/memory stages; stall logic consumes A_busy/B_busy.
// PARAMETERS
//  NBIT      16   data width
//  NREG      16   number of registers (power of 2, >=2)
//  AW        $clog2(NREG)  address width (derived, localparam)
//  ZERO_REG  0    1: register 0 reads 0, ignores writes, never busy
// PORTS
//  clk      in   1     single clock; all state updates on rising edge
//  reset_n  in   1     asynchronous, active-low reset
//  D        in   NBIT  W0 (ALU) write data
//  DA       in   AW    W0 write address
//  RW       in   1     W0 write enable
//  LD       in   NBIT  W1 (load return) write data
//  LDA      in   AW    W1 write address
//  LW       in   1     W1 write enable; also clears busy[LDA]
//  SB_SET   in   1     mark register SBA busy (load issued)
//  SBA      in   AW    scoreboard set address
//  CLR      in   1     start clear sweep (single-cycle pulse)
//  AA, BA   in   AW    read addresses
//  A, B     out  NBIT  read data (combinational, bypassed)
//  A_busy   out  1     busy[AA] after bypass rules
//  B_busy   out  1     busy[BA] after bypass rules
//  ready    out  1     1 = IDLE (writes/SB_SET accepted); 0 during sweep
// BEHAVIOUR
//  Reset (reset_n=0, async): all regs 0, busy all 0, state IDLE, sweep cnt 0, ready=1.
//  Writes (IDLE only): at rising clk, RW writes D->reg[DA]; LW writes LD->reg[LDA].
//   RW & LW same address same cycle: W1 (LD) wins. ZERO_REG=1 & addr 0: write dropped.
//  Scoreboard (IDLE only): SB_SET sets busy[SBA]; LW clears busy[LDA].
//   SB_SET and LW same address same cycle: busy ends 1 (set wins). Reg data still takes LD.
//  Reads, combinational, priority high->low:
//   ZERO_REG=1 & addr 0 -> 0; IDLE & LW & LDA==addr -> LD; IDLE & RW & DA==addr -> D; else reg[addr].
//   x_busy = busy[addr] & ~(IDLE & LW & LDA==addr); forced 0 for hard-zero r0.
//   SB_SET does not affect same-cycle busy outputs (visible next cycle).
//  Sweep FSM: IDLE --CLR--> SWEEP. In SWEEP: each cycle reg[cnt]<=0, busy[cnt]<=0, cnt++;
//   when cnt==NREG-1 that cycle, next state IDLE, cnt<=0. Sweep = exactly NREG cycles,
//   ready=0 throughout, ready=1 the cycle after last clear.
//   In SWEEP: RW, LW, SB_SET, CLR ignored (caller must hold); reads return stored values, no bypass.
//   CLR coincident with RW/LW in IDLE: write is performed, then sweep starts next cycle.
//  Reset asserted mid-sweep: immediate return to reset state; sweep abandoned.
//  No X on outputs for any in-range address; AW exactly covers NREG so no out-of-range case.
// STRUCTURE
//  Shared package rf_pkg: localparam state encoding (RF_IDLE=1'b0, RF_SWEEP=1'b1), defaults
//   RF_NBIT=16, RF_NREG=16 reused by decode/hazard units.
//  One sub-module, rf_read_port (instantiated twice): addr, storage view, bypass inputs,
//   busy vector -> data, busy. Storage, scoreboard and sweep FSM stay in top.
// TESTING
//  1 Reset: reset_n=0 then 1 -> A=B=0, busy=0, ready=1 for all AA/BA 0..15.
//  2 Write/bypass: RW=1,DA=3,D=16'hBEEF, AA=3 same cycle -> A=BEEF combinationally; next cycle
//    RW=0 -> A=BEEF from storage.
//  3 Collision: RW DA=5 D=1111, LW LDA=5 LD=2222 same cycle -> reg5=2222; BA=5 showed 2222 that cycle.
//  4 Scoreboard: SB_SET SBA=7 -> next cycle A_busy=1 (AA=7); LW LDA=7 -> A_busy=0 that cycle, A=LD;
//    SB_SET+LW both on 7 -> busy stays 1.
//  5 Sweep: fill regs with i+1, busy[2]=1, pulse CLR -> ready=0 for 16 cycles, RW during sweep
//    has no effect, then all regs 0, busy 0, ready=1; reset_n pulse at sweep cycle 6 -> IDLE at once.
//  6 ZERO_REG=1 (NREG=8, NBIT=32): RW DA=0 D=FFFF_FFFF, SB_SET SBA=0 -> A=0, A_busy=0 for AA=0.

Source files
------------

// File: rtl/register_file_sb_pkg.sv
// Shared definitions for the register file and the decode/hazard units that size themselves against it.
package rf_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

    localparam int RF_NBIT = 16;
    localparam int RF_NREG = 16;

endpackage : rf_pkg

// File: rtl/register_file_sb_read_port.sv
// One combinational read port: hard-zero r0, load-return bypass, ALU bypass, then storage.
module rf_read_port #(
    parameter  int NBIT     = 16,
    parameter  int NREG     = 16,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(NREG)
) (
    input  logic [AW-1:0]              addr,
    input  logic [NREG-1:0][NBIT-1:0]  regs,
    input  logic [NREG-1:0]            busy_vec,
    input  logic                       idle,
    input  logic                       rw,
    input  logic [AW-1:0]              da,
    input  logic [NBIT-1:0]            d,
    input  logic                       lw,
    input  logic [AW-1:0]              lda,
    input  logic [NBIT-1:0]            ld,
    output logic [NBIT-1:0]            data,
    output logic                       busy
);

    logic hard_zero;
    logic bypass_w1;
    logic bypass_w0;

    assign hard_zero = (ZERO_REG != 0) && (addr == '0);
    assign bypass_w1 = idle && lw && (lda == addr);
    assign bypass_w0 = idle && rw && (da == addr);

    // NOTE: output gets a default before the priority chain so no path leaves it unassigned (no latch).
    always_comb begin
        data = regs[addr];
        if (hard_zero) begin
            data = '0;
        end else if (bypass_w1) begin
            data = ld;
        end else if (bypass_w0) begin
            data = d;
        end
    end

    // A returning load resolves the hazard in the same cycle its data is forwarded.
    assign busy = !hard_zero && busy_vec[addr] && !bypass_w1;

endmodule : rf_read_port

// File: rtl/register_file_sb.sv
// NREG x NBIT register file with two write ports, load scoreboard, write-through bypass and clear sweep.
module register_file_sb
    import rf_pkg::*;
#(
    parameter  int NBIT     = RF_NBIT,
    parameter  int NREG     = RF_NREG,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NBIT-1:0] D,
    input  logic [AW-1:0]   DA,
    input  logic            RW,
    input  logic [NBIT-1:0] LD,
    input  logic [AW-1:0]   LDA,
    input  logic            LW,
    input  logic            SB_SET,
    input  logic [AW-1:0]   SBA,
    input  logic            CLR,
    input  logic [AW-1:0]   AA,
    input  logic [AW-1:0]   BA,
    output logic [NBIT-1:0] A,
    output logic [NBIT-1:0] B,
    output logic            A_busy,
    output logic            B_busy,
    output logic            ready
);

    rf_state_e                 state, state_next;
    logic [AW-1:0]             cnt;
    logic [NREG-1:0][NBIT-1:0] regs;
    logic [NREG-1:0]           busy;
    logic                      idle;
    logic                      sweep_last;
    logic                      w0_en, w1_en, sb_en;

    function automatic logic is_hard_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign idle       = (state == RF_IDLE);
    assign ready      = idle;
    assign sweep_last = (state == RF_SWEEP) && (cnt == AW'(NREG - 1));
    assign w0_en      = idle && RW && !is_hard_zero(DA);
    assign w1_en      = idle && LW && !is_hard_zero(LDA);
    assign sb_en      = idle && SB_SET && !is_hard_zero(SBA);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RF_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RF_IDLE:  if (CLR) state_next = RF_SWEEP;
            RF_SWEEP: if (sweep_last) state_next = RF_IDLE;
            default:  state_next = RF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == RF_SWEEP) begin
            cnt <= sweep_last ? '0 : cnt + AW'(1);
        end
    end

    // NOTE: storage is flops, not a RAM macro, so a whole-array async reset is legitimate here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs <= '0;
        end else if (idle) begin
            // NOTE: the later non-blocking assignment wins, giving W1 priority on an address collision.
            if (w0_en) regs[DA]  <= D;
            if (w1_en) regs[LDA] <= LD;
        end else begin
            regs[cnt] <= '0;
        end
    end

    // Set after clear so a load issued to the register its predecessor is returning to stays busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else if (idle) begin
            if (LW)    busy[LDA] <= 1'b0;
            if (sb_en) busy[SBA] <= 1'b1;
        end else begin
            busy[cnt] <= 1'b0;
        end
    end

    rf_read_port #(.NBIT(NBIT), .NREG(NREG), .ZERO_REG(ZERO_REG)) u_read_a (
        .addr(AA), .regs(regs), .busy_vec(busy), .idle(idle),
        .rw(RW), .da(DA), .d(D), .lw(LW), .lda(LDA), .ld(LD),
        .data(A), .busy(A_busy)
    );

    rf_read_port #(.NBIT(NBIT), .NREG(NREG), .ZERO_REG(ZERO_REG)) u_read_b (
        .addr(BA), .regs(regs), .busy_vec(busy), .idle(idle),
        .rw(RW), .da(DA), .d(D), .lw(LW), .lda(LDA), .ld(LD),
        .data(B), .busy(B_busy)
    );

endmodule : register_file_sb
